// File: rtl/player_draw.sv
// -----------------------------------------------------------------------------
// player_draw
//
// Overlays the player sprite on the VGA pixel stream coming from the
// background layer. Position and animation state from the movement controller
// are captured once per frame, at the rising edge of vertical blanking, so a
// sprite can never tear when those inputs change mid-frame. For every visible
// pixel inside the sprite box a sprite-sheet ROM address is generated, with
// horizontal mirroring when the player faces left. Non-transparent sprite
// pixels replace the background colour.
//
// Pipeline (every output is exactly 3 clocks behind its input pixel):
//   stage 1: rom_addr, hit, timing and background colour registered
//   stage 2: ROM returns rom_data; hit, timing and colour delayed again
//   stage 3: composited colour and timing registered onto the outputs
//
// Ports
//   clk, rst            pixel clock, synchronous active-high reset
//   hcount_in/vcount_in pixel coordinates from the background stage
//   hsync_in/vsync_in   sync pulses
//   hblnk_in/vblnk_in   blanking flags
//   rgb_in              background colour, 4:4:4
//   pos_x/pos_y         player top-left corner, from the movement controller
//   sprite_control      {right, jump, idle, cnt[3:0]}
//   rom_addr            registered sprite-sheet address
//   rom_data            ROM pixel, valid one clock after rom_addr
//   *_out               timing delayed 3 clocks
//   rgb_out             composited colour
// -----------------------------------------------------------------------------
module player_draw #(
   parameter int          SPRITE_W = 32,
   parameter int          SPRITE_H = 32,
   parameter int          N_FRAMES = 17,
   parameter int          ADDR_W   = 15,
   parameter logic [11:0] TRANSP   = 12'hF0F
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [10:0]       hcount_in,
   input  logic [10:0]       vcount_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              hblnk_in,
   input  logic              vblnk_in,
   input  logic [11:0]       rgb_in,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic [6:0]        sprite_control,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   output logic [10:0]       hcount_out,
   output logic [10:0]       vcount_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              hblnk_out,
   output logic              vblnk_out,
   output logic [11:0]       rgb_out
);

   localparam int COL_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int ROW_W   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int FRAME_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
   } timing_t;

   // sprite_control fields
   localparam int CTRL_RIGHT = 6;
   localparam int CTRL_JUMP  = 5;
   localparam int CTRL_IDLE  = 4;

   // ---------------------------------------------------------------------------
   // Frame latch: shadow copies of position/animation, updated only when
   // vertical blanking starts.
   // ---------------------------------------------------------------------------
   logic       vblnk_prev;
   logic       shadow_valid;
   logic [9:0] shadow_x;
   logic [9:0] shadow_y;
   logic [6:0] shadow_ctrl;

   // NOTE: sequential state always uses non-blocking assignments so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_prev   <= 1'b0;
         shadow_valid <= 1'b0;
         shadow_x     <= '0;
         shadow_y     <= '0;
         shadow_ctrl  <= '0;
      end else begin
         vblnk_prev <= vblnk_in;
         if (vblnk_in && !vblnk_prev) begin
            shadow_valid <= 1'b1;
            shadow_x     <= pos_x;
            shadow_y     <= pos_y;
            shadow_ctrl  <= sprite_control;
         end
      end
   end

   // cnt[3] does not take part in frame selection.
   logic unused_cnt_msb;
   assign unused_cnt_msb = shadow_ctrl[3];

   // ---------------------------------------------------------------------------
   // Hit test and address generation
   // ---------------------------------------------------------------------------
   logic [10:0]        sx, sy, x_end, y_end;
   logic               hit;
   logic [COL_W-1:0]   col, col_m;
   logic [ROW_W-1:0]   row;
   logic [FRAME_W-1:0] frame_sel;
   logic [ADDR_W-1:0]  addr_next;

   // NOTE: every variable gets a value on every path through this block;
   // a path that left one unassigned would infer a latch.
   always_comb begin
      // Box limits are 11 bits wide, so a sprite near x=1023 runs past the
      // visible area and clips instead of wrapping back to column 0.
      sx    = {1'b0, shadow_x};
      sy    = {1'b0, shadow_y};
      x_end = sx + 11'(SPRITE_W);
      y_end = sy + 11'(SPRITE_H);

      hit = shadow_valid && !hblnk_in && !vblnk_in &&
            (hcount_in >= sx) && (hcount_in < x_end) &&
            (vcount_in >= sy) && (vcount_in < y_end);

      col = COL_W'(hcount_in - sx);
      row = ROW_W'(vcount_in - sy);

      // The sheet is drawn facing right; facing left reads columns backwards.
      if (shadow_ctrl[CTRL_RIGHT]) col_m = col;
      else                         col_m = COL_W'(SPRITE_W - 1) - col;

      // Jump wins over idle; walk and jump cycle through 8 frames each.
      if (shadow_ctrl[CTRL_JUMP])      frame_sel = FRAME_W'(9) + FRAME_W'(shadow_ctrl[2:0]);
      else if (shadow_ctrl[CTRL_IDLE]) frame_sel = '0;
      else                             frame_sel = FRAME_W'(1) + FRAME_W'(shadow_ctrl[2:0]);

      addr_next = ADDR_W'(frame_sel) * ADDR_W'(SPRITE_W * SPRITE_H) +
                  ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col_m);
   end

   // ---------------------------------------------------------------------------
   // Three-stage pixel pipeline
   // ---------------------------------------------------------------------------
   timing_t     timing_in, timing_d1, timing_d2;
   logic        hit_d1, hit_d2;
   logic [11:0] rgb_d1, rgb_d2;

   assign timing_in = '{hcount: hcount_in, vcount: vcount_in,
                        hsync: hsync_in, vsync: vsync_in,
                        hblnk: hblnk_in, vblnk: vblnk_in};

   always_ff @(posedge clk) begin
      if (rst) begin
         rom_addr   <= '0;
         hit_d1     <= 1'b0;
         timing_d1  <= '0;
         rgb_d1     <= '0;
         hit_d2     <= 1'b0;
         timing_d2  <= '0;
         rgb_d2     <= '0;
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         // stage 1: the address is only updated for sprite pixels
         if (hit) rom_addr <= addr_next;
         hit_d1    <= hit;
         timing_d1 <= timing_in;
         rgb_d1    <= rgb_in;

         // stage 2: runs alongside the ROM read
         hit_d2    <= hit_d1;
         timing_d2 <= timing_d1;
         rgb_d2    <= rgb_d1;

         // stage 3: rom_data now belongs to the pixel carried in stage 2
         hcount_out <= timing_d2.hcount;
         vcount_out <= timing_d2.vcount;
         hsync_out  <= timing_d2.hsync;
         vsync_out  <= timing_d2.vsync;
         hblnk_out  <= timing_d2.hblnk;
         vblnk_out  <= timing_d2.vblnk;
         rgb_out    <= (hit_d2 && (rom_data != TRANSP)) ? rom_data : rgb_d2;
      end
   end

endmodule

// File: doc/player_draw.md
# player_draw

Draws the player sprite into the VGA pixel stream. It consumes the `x`, `y` and `sprite_control` outputs of the player movement controller and the timing/RGB stream of the background layer. It samples the position/animation once per frame, generates sprite-sheet ROM addresses with horizontal mirroring, and overlays non-transparent sprite pixels. It sits in the VGA chain after the background/platform draw stage and before the output stage.

## Interface
Parameters:
- SPRITE_W, 32, sprite width in pixels
- SPRITE_H, 32, sprite height in pixels
- N_FRAMES, 17, frames in sheet (0 idle, 1–8 walk, 9–16 jump)
- ADDR_W, 15, ROM address width (≥ clog2(N_FRAMES·SPRITE_W·SPRITE_H))
- TRANSP, 12'hF0F, colour key treated as transparent

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hcount_in, vcount_in  in  11 each  pixel coordinates
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing
- rgb_in  in  12  background colour, 4:4:4
- pos_x  in  10  player left x, from movement controller
- pos_y  in  10  player top y, from movement controller
- sprite_control  in  7  {right, jump, idle, cnt[3:0]}
- rom_addr  out  ADDR_W  sprite-sheet address, registered
- rom_data  in  12  ROM pixel, valid one cycle after rom_addr
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  timing delayed 3 cycles
- rgb_out  out  12  composited colour

## Operation
- Reset values: all outputs 0, all pipeline stages 0, shadow registers 0, `shadow_valid` 0.
- Frame latch: on a cycle where `vblnk_in`=1 and the registered previous `vblnk_in`=0, copy pos_x, pos_y and sprite_control into the shadow registers and set `shadow_valid`=1. The shadow registers do not change at any other time, so mid-frame input changes never tear the sprite.
- Frame select from the shadow sprite_control:
  - jump=1 → frame 9+cnt[2:0] (jump has priority over idle)
  - else idle=1 → frame 0
  - else → frame 1+cnt[2:0]
  - cnt[3] is ignored.
- Hit test: hit = shadow_valid & !hblnk_in & !vblnk_in & hcount_in ≥ sx & hcount_in < sx+SPRITE_W & vcount_in ≥ sy & vcount_in < sy+SPRITE_H.
  - Sums are computed in 11 bits, so a sprite at x=1023 clips and does not wrap to column 0.
- Column/row: col = hcount_in − sx and row = vcount_in − sy, evaluated only when hit.
  - Mirroring: if right=0, col ← SPRITE_W−1−col. The sheet is stored facing right.
- Address: frame·SPRITE_W·SPRITE_H + row·SPRITE_W + col, truncated to ADDR_W. When hit=0, rom_addr holds its previous value.
- Compositing (stage 3): rgb_out = rom_data if hit_d2=1 and rom_data≠TRANSP; otherwise rgb_in_d2.
- During blanking, rgb_in passes through unchanged, delayed.

## Timing
- Stage 1, edge after input cycle n: rom_addr, hit_d1, timing_d1, rgb_d1 registered.
- Stage 2: ROM returns rom_data. hit_d2, timing_d2 and rgb_d2 are registered in parallel.
- Stage 3: all outputs registered. Latency is exactly 3 clocks for every output, including rgb_out for non-sprite pixels.
- The shadow-register update happens at the same edge as the vblnk rise is registered. Pixels of the frame that follows use the new values. No visible pixel sees a partial update, because the latch occurs in blanking.
- rst asserted mid-frame: all state clears on the next edge. No sprite is drawn until the next vblnk rising edge has re-armed `shadow_valid`. The background passes through with 3-cycle latency from the first cycle after rst deasserts.

## Test plan
- Reset/passthrough: hold rst 2 cycles, then drive a frame with no vblnk rise yet and rgb_in=12'h123 → rgb_out=12'h123 exactly 3 cycles later; never sprite pixels; all outputs 0 while in reset.
- Right-facing walk: latch pos_x=100, pos_y=200, sprite_control=7'b1000011; at hcount=100, vcount=200 → rom_addr=4·1024+0=4096 one cycle later; at hcount=131, vcount=231 → rom_addr=4096+31·32+31=5119; hcount=132 → no hit, rgb_out=rgb_in.
- Mirror: same as above with sprite_control=7'b0000011 → at hcount=100, vcount=200, rom_addr=4096+31=4127.
- Priority/idle: sprite_control=7'b1110101 → frame 14 (base 14336); 7'b1010000 → frame 0 (base 0); 7'b1001111 → cnt[3] ignored, frame 8.
- Transparency: ROM model returns 12'hF0F for one address and 12'hABC elsewhere inside the box → those pixels show rgb_in; others show 12'hABC.
- Frame latch/tearing and edge clip: change pos_x from 100 to 300 mid-frame → the sprite stays at 100 until after the next vblnk rise. pos_x=1010 → hit only for hcount 1010–1023, with no wrap at hcount 0–9.
